serial_nibble_rx: RTL and testbench

Framed serial-to-parallel receiver: samples a single-bit serial line once per `cen` tick, strips a start/stop frame, and delivers each assembled word on `PO` with a one-cycle `valid` strobe. It sits at the receiving end of the serial link whose transmitter serialises the contents of the team's parallel-load `cen`-gated registers. Framing errors are flagged, and the previously delivered word is kept.

---
 rtl/serial_nibble_rx_pkg.sv | 24 ++
 rtl/serial_nibble_rx_shift.sv | 39 +++
 rtl/serial_nibble_rx.sv | 147 ++++++++++++++
 tb/tb_serial_nibble_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_nibble_rx_pkg.sv
// Shared types and constants for the framed serial nibble receiver.
// Optional even parity is selected with SERIAL_NIBBLE_RX_PARITY_EN.
package serial_nibble_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic RX_IDLE_LEVEL    = 1'b1;
    localparam int   RX_DEFAULT_WIDTH = 4;

    // State entered once the last data bit has been shifted in.
    function automatic rx_state_t rx_after_data();
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        return PARITY;
`else
        return STOP;
`endif
    endfunction

endpackage

// File: rtl/serial_nibble_rx_shift.sv
// WIDTH-bit right-shift register: new bits enter at the MSB so the first
// bit received ends up in bit 0. Asynchronous active-low clear.
module rx_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            always_comb begin
                sreg_d[gi] = shift_en ? sreg_q[gi+1] : sreg_q[gi];
            end
        end
    endgenerate

    always_comb begin
        sreg_d[WIDTH-1] = shift_en ? din : sreg_q[WIDTH-1];
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign q = sreg_q;

endmodule

// File: rtl/serial_nibble_rx.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits LSB first,
// optional even parity (SERIAL_NIBBLE_RX_PARITY_EN), stop bit.
module serial_nibble_rx
    import serial_nibble_rx_pkg::*;
#(
    parameter int WIDTH = RX_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             SI,
    output logic [WIDTH-1:0] PO,
    output logic             valid,
    output logic             ferr,
    output logic             perr,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sreg;
    logic             shift_en;

    assign shift_en = cen && (state_q == DATA);

    rx_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .clr_n    (rst),
        .shift_en (shift_en),
        .din      (SI),
        .q        (sreg)
    );

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    logic par_err_q, par_err_d;
    logic perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        po_d    = po_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        par_err_d = par_err_q;
        perr_d    = 1'b0;
`endif
        if (cen) begin
            case (state_q)
                IDLE: begin
                    // No start-bit re-check: any low sample opens a frame.
                    if (SI != RX_IDLE_LEVEL) begin
                        state_d = DATA;
                        cnt_d   = '0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = rx_after_data();
                    end
                end
                PARITY: begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                    par_err_d = SI ^ (^sreg);
                    state_d   = STOP;
`else
                    state_d = IDLE;
`endif
                end
                STOP: begin
                    if (SI == RX_IDLE_LEVEL) begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                        if (par_err_q) begin
                            perr_d = 1'b1;
                        end else begin
                            po_d    = sreg;
                            valid_d = 1'b1;
                        end
`else
                        po_d    = sreg;
                        valid_d = 1'b1;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                    // A low stop bit is consumed here, never treated as a start.
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            po_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            po_q    <= po_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
            perr_q    <= perr_d;
        end
    end
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    assign PO    = po_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Self-checking bench for serial_nibble_rx: frame table, corner sequences and
// a random bit stream checked against a frame-level parser.
module tb_serial_nibble_rx;

    localparam int W = 4;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int L = W + 2 + (PAR_EN ? 1 : 0);
    localparam int MAXS = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cen = 1'b0;
    logic         si  = 1'b1;
    logic [W-1:0] po;
    logic         valid, ferr, perr, busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] ref_po = '0;

    serial_nibble_rx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .SI    (si),
        .PO    (po),
        .valid (valid),
        .ferr  (ferr),
        .perr  (perr),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] data;
        logic         stop;
        int           idle;
        bit           hold;
        logic [W-1:0] e_po;
        logic         e_v;
        logic         e_f;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s = %0d", nm, act);
        end
    endtask

    task automatic tick(input logic b);
        si  = b;
        cen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame with cen every third clk; checks the stop-tick outputs and pulse width.
    task automatic send_frame(input string nm, input logic [W-1:0] data, input logic par,
                              input logic stop, input int idle, input bit hold,
                              input logic [W-1:0] e_po, input logic e_v,
                              input logic e_f, input logic e_p);
        repeat (idle) begin
            tick(1'b1);
            wait_clks(2);
        end
        tick(1'b0);
        chk({nm, "_busy_start"}, 32'(busy), 32'd1);
        wait_clks(2);
        for (int i = 0; i < W; i++) begin
            tick(data[i]);
            wait_clks((hold && i == 1) ? 10 : 2);
        end
        if (PAR_EN) begin
            tick(par);
            wait_clks(2);
        end
        tick(stop);
        chk({nm, "_po"},    32'(po),    32'(e_po));
        chk({nm, "_valid"}, 32'(valid), 32'(e_v));
        chk({nm, "_ferr"},  32'(ferr),  32'(e_f));
        chk({nm, "_perr"},  32'(perr),  32'(e_p));
        chk({nm, "_busy_end"}, 32'(busy), 32'd0);
        wait_clks(1);
        chk({nm, "_strobes_fall"}, 32'({valid, ferr, perr}), 32'd0);
        wait_clks(1);
        ref_po = e_po;
    endtask

    // Random-stream reference: parse the tick sequence frame by frame.
    logic         s_bit  [MAXS];
    logic [W-1:0] x_po   [MAXS];
    logic         x_v    [MAXS];
    logic         x_f    [MAXS];
    logic         x_p    [MAXS];
    logic         x_busy [MAXS];
    int           n_bits;

    task automatic build_model(input logic [W-1:0] start_po);
        int i;
        logic [W-1:0] cur;
        cur = start_po;
        i = 0;
        while (i < n_bits) begin
            x_v[i] = 1'b0; x_f[i] = 1'b0; x_p[i] = 1'b0; x_po[i] = cur;
            if (s_bit[i] == 1'b1 || i + L - 1 >= n_bits) begin
                x_busy[i] = 1'b0;
                i++;
            end else begin
                int st;
                int val;
                logic pbad;
                st  = i + L - 1;
                val = 0;
                for (int k = 0; k < W; k++) val += int'(s_bit[i+1+k]) << k;
                pbad = 1'b0;
                if (PAR_EN) pbad = (s_bit[i+1+W] != ^(W'(val)));
                for (int k = i; k < st; k++) begin
                    x_v[k] = 1'b0; x_f[k] = 1'b0; x_p[k] = 1'b0;
                    x_po[k] = cur; x_busy[k] = 1'b1;
                end
                x_v[st] = 1'b0; x_f[st] = 1'b0; x_p[st] = 1'b0; x_busy[st] = 1'b0;
                if (!s_bit[st])  x_f[st] = 1'b1;
                else if (pbad)   x_p[st] = 1'b1;
                else begin
                    x_v[st] = 1'b1;
                    cur = W'(val);
                end
                x_po[st] = cur;
                i = st + 1;
            end
        end
    endtask

    initial begin
        vecs[0] = '{data: 4'd12, stop: 1'b1, idle: 2, hold: 1'b0, e_po: 4'd12, e_v: 1'b1, e_f: 1'b0};
        vecs[1] = '{data: 4'd9,  stop: 1'b0, idle: 1, hold: 1'b0, e_po: 4'd12, e_v: 1'b0, e_f: 1'b1};
        vecs[2] = '{data: 4'd9,  stop: 1'b1, idle: 1, hold: 1'b1, e_po: 4'd9,  e_v: 1'b1, e_f: 1'b0};
        vecs[3] = '{data: 4'd7,  stop: 1'b1, idle: 0, hold: 1'b0, e_po: 4'd7,  e_v: 1'b1, e_f: 1'b0};
        vecs[4] = '{data: 4'd0,  stop: 1'b1, idle: 0, hold: 1'b0, e_po: 4'd0,  e_v: 1'b1, e_f: 1'b0};
        vecs[5] = '{data: 4'd15, stop: 1'b0, idle: 3, hold: 1'b0, e_po: 4'd0,  e_v: 1'b0, e_f: 1'b1};
        vecs[6] = '{data: 4'd10, stop: 1'b1, idle: 0, hold: 1'b0, e_po: 4'd10, e_v: 1'b1, e_f: 1'b0};
        vecs[7] = '{data: 4'd5,  stop: 1'b1, idle: 1, hold: 1'b0, e_po: 4'd5,  e_v: 1'b1, e_f: 1'b0};

        // Reset state
        wait_clks(3);
        chk("reset_po",    32'(po),    32'd0);
        chk("reset_flags", 32'({valid, ferr, perr, busy}), 32'd0);
        rst = 1'b1;
        wait_clks(2);

        // Table of frames (parity bit always correct)
        for (int v = 0; v < 8; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].data, ^vecs[v].data, vecs[v].stop,
                       vecs[v].idle, vecs[v].hold, vecs[v].e_po, vecs[v].e_v,
                       vecs[v].e_f, 1'b0);
        end

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        send_frame("par_ok",  4'd14, 1'b1, 1'b1, 1, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0);
        send_frame("par_bad", 4'd14, 1'b0, 1'b1, 1, 1'b0, 4'd14, 1'b0, 1'b0, 1'b1);
`endif

        // Reset mid-frame after two data bits of 15
        tick(1'b1); wait_clks(2);
        tick(1'b0); wait_clks(2);
        tick(1'b1); wait_clks(2);
        tick(1'b1);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_po",   32'(po),   32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        wait_clks(4);
        chk("midrst_hold", 32'({valid, ferr, perr, busy, po}), 32'd0);
        rst = 1'b1;
        wait_clks(2);
        send_frame("after_rst", 4'd14, 1'b1, 1'b1, 1, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0);

        // Idle line
        for (int t = 0; t < 20; t++) begin
            tick(1'b1);
            chk($sformatf("idle%0d", t), 32'({busy, valid, ferr}), 32'd0);
            wait_clks(2);
        end

        // Random stream
        n_bits = 0;
        for (int f = 0; f < 40; f++) begin
            int gap;
            logic [W-1:0] d;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin s_bit[n_bits] = 1'b1; n_bits++; end
            d = W'($urandom);
            s_bit[n_bits] = 1'b0; n_bits++;
            for (int k = 0; k < W; k++) begin s_bit[n_bits] = d[k]; n_bits++; end
            if (PAR_EN) begin
                s_bit[n_bits] = (^d) ^ ($urandom_range(0, 4) == 0);
                n_bits++;
            end
            s_bit[n_bits] = ($urandom_range(0, 4) != 0);
            n_bits++;
        end
        repeat (L) begin s_bit[n_bits] = 1'b1; n_bits++; end
        build_model(ref_po);
        for (int t = 0; t < n_bits; t++) begin
            int gap;
            tick(s_bit[t]);
            chk($sformatf("rnd%0d_po", t),    32'(po),    32'(x_po[t]));
            chk($sformatf("rnd%0d_valid", t), 32'(valid), 32'(x_v[t]));
            chk($sformatf("rnd%0d_ferr", t),  32'(ferr),  32'(x_f[t]));
            chk($sformatf("rnd%0d_perr", t),  32'(perr),  32'(x_p[t]));
            chk($sformatf("rnd%0d_busy", t),  32'(busy),  32'(x_busy[t]));
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                wait_clks(1);
                chk($sformatf("rnd%0d_fall", t), 32'({valid, ferr, perr}), 32'd0);
                wait_clks(gap - 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
